// File: rtl/game_judge.sv
// Clocked N x N two-player line judge: accepts one move at a time, then scans
// the four line directions through the placed cell, one direction per cycle.
module game_judge #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int RW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic              move_player,
    input  logic [RW-1:0]     move_row,
    input  logic [RW-1:0]     move_col,
    output logic              move_err,
    output logic              turn,
    output logic [2*N*N-1:0]  board,
    output logic [1:0]        result,
    output logic              done
);

    localparam int CW = $clog2(N*N+1);
    localparam int IW = $clog2(2*N*N);

    typedef enum logic [1:0] {IDLE, CHECK, OVER} state_e;

    state_e            state_q, state_d;
    logic [2*N*N-1:0]  board_q, board_d;
    logic              turn_q, turn_d;
    logic [1:0]        result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [RW-1:0]     row_q, row_d, col_q, col_d;
    logic              plyr_q, plyr_d;
    logic [1:0]        dir_q, dir_d;
    logic              win_q, win_d;

    // Off-board coordinates read as "no mark" so run scans stop at the edge.
    function automatic logic mark_at(input logic [2*N*N-1:0] b, input int r,
                                     input int c, input logic p);
        logic         m;
        logic [IW-1:0] idx;
        m = 1'b0;
        if (r >= 0 && r < N && c >= 0 && c < N) begin
            idx = IW'(2*(r*N+c) + int'(p));
            m   = b[idx];
        end
        return m;
    endfunction

    int   dr, dc, run;
    logic go_f, go_b;
    logic in_rng, occupied, illegal, hit;
    logic [IW-1:0] widx;

    // Run length through the latched cell along the current direction.
    always_comb begin
        dr   = 0;
        dc   = 1;
        case (dir_q)
            2'd0: begin dr = 0; dc = 1;  end
            2'd1: begin dr = 1; dc = 0;  end
            2'd2: begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        run  = 1;
        go_f = 1'b1;
        go_b = 1'b1;
        for (int i = 1; i < K; i++) begin
            if (go_f && mark_at(board_q, int'(row_q) + i*dr, int'(col_q) + i*dc, plyr_q))
                run = run + 1;
            else
                go_f = 1'b0;
            if (go_b && mark_at(board_q, int'(row_q) - i*dr, int'(col_q) - i*dc, plyr_q))
                run = run + 1;
            else
                go_b = 1'b0;
        end
        hit = (run >= K);
    end

    always_comb begin
        in_rng   = (int'(move_row) < N) && (int'(move_col) < N);
        occupied = in_rng &&
                   (mark_at(board_q, int'(move_row), int'(move_col), 1'b0) ||
                    mark_at(board_q, int'(move_row), int'(move_col), 1'b1));
        illegal  = !in_rng || occupied || (move_player != turn_q);
        widx     = IW'(2*(int'(move_row)*N + int'(move_col)) + int'(move_player));
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        row_d    = row_q;
        col_d    = col_q;
        plyr_d   = plyr_q;
        dir_d    = dir_q;
        win_d    = win_q;

        if (new_game) begin
            state_d  = IDLE;
            board_d  = '0;
            turn_d   = 1'b0;
            result_d = 2'b00;
            cnt_d    = '0;
            win_d    = 1'b0;
            dir_d    = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (move_valid) begin
                        if (illegal) begin
                            err_d = 1'b1;
                        end else begin
                            board_d[widx] = 1'b1;
                            cnt_d   = cnt_q + 1'b1;
                            row_d   = move_row;
                            col_d   = move_col;
                            plyr_d  = move_player;
                            dir_d   = 2'd0;
                            win_d   = 1'b0;
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    win_d = win_q | hit;
                    dir_d = dir_q + 2'd1;
                    if (dir_q == 2'd3) begin
                        // A win on the last free cell outranks the draw.
                        if (win_q | hit) begin
                            result_d = plyr_q ? 2'b10 : 2'b01;
                            state_d  = OVER;
                        end else if (int'(cnt_q) == N*N) begin
                            result_d = 2'b11;
                            state_d  = OVER;
                        end else begin
                            turn_d  = ~turn_q;
                            state_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            board_q  <= '0;
            turn_q   <= 1'b0;
            result_q <= 2'b00;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            plyr_q   <= 1'b0;
            dir_q    <= 2'd0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            turn_q   <= turn_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            row_q    <= row_d;
            col_q    <= col_d;
            plyr_q   <= plyr_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
        end
    end

    assign move_ready = (state_q == IDLE);
    assign done       = (state_q == OVER);
    assign move_err   = err_q;
    assign turn       = turn_q;
    assign board      = board_q;
    assign result     = result_q;

endmodule

// File: doc/game_judge.md
# game_judge

Parametrised, clocked successor to the combinational tic-tac-toe winner logic. Holds an N×N two-player board, accepts moves via valid/ready, and checks each accepted move for a K-in-a-row line through the placed cell in all four directions. Reports win/draw status and an illegal-move pulse. Sits between the move-input collector and the LED display/result logic.

## Interface
- N, 3, board side length; legal range 3..8
- K, 3, run length needed to win; 3 <= K <= N
- RW, $clog2(N), row/column index width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- new_game  in  1  synchronous clear to empty board; priority below rst_n, above all else
- move_valid  in  1  move request
- move_ready  out  1  high only in IDLE
- move_player  in  1  0 = P1, 1 = P2
- move_row, move_col  in  RW  target cell
- move_err  out  1  one-cycle pulse on a rejected move
- turn  out  1  player expected next (0 = P1)
- board  out  2*N*N  cell i = r*N+c: bit 2i = P1 mark, bit 2i+1 = P2 mark
- result  out  2  00 playing, 01 P1 win, 10 P2 win, 11 draw
- done  out  1  high in OVER

## Operation
- States: IDLE, CHECK, OVER.
- Reset (rst_n=0) or new_game=1 at a clock edge puts the block in IDLE with board=0, turn=0, result=00, done=0, move_err=0, move count=0, and move_ready=1. This applies from any state, including mid-CHECK.
- A move is consumed on an edge with move_valid && move_ready.
- The move is illegal if move_row >= N, move_col >= N, the cell is non-zero, or move_player != turn.
  - Illegal move: board, turn and count unchanged; move_err=1 for the next cycle; stay in IDLE.
- Legal move:
  - Set the player's bit in the cell and increment the count.
  - Latch row, col and player; go to CHECK with direction d=0.
- CHECK runs one direction per cycle, d = 0 horizontal, 1 vertical, 2 main diagonal (r+1,c+1), 3 anti-diagonal (r+1,c-1).
  - run = 1 + forward same-player cells + backward same-player cells. Each side stops at the first non-matching cell or the board edge, and counts at most K-1.
  - run >= K sets the sticky internal win flag.
- After d=3:
  - If win: result = 01/10 per the latched player; go to OVER.
  - Else if count == N*N: result = 11; go to OVER.
  - Else: toggle turn; go to IDLE.
- A win on the final cell reports a win, not a draw.
- OVER: move_ready=0, moves ignored, move_err stays 0. Board and result hold until new_game or reset.
- The count is $clog2(N*N+1) bits wide and never wraps, because moves stop at OVER.

## Timing
- Legal move accepted at edge E0:
  - board visible after E0.
  - CHECK occupies the cycles following edges E0..E3.
  - result, done and turn update at edge E4.
  - move_ready=1 after E4 if the game continues, so the earliest next acceptance is E5.
- Latency from acceptance to result is fixed at 4 cycles; there is no early exit.
- Illegal move accepted at E0: move_err high for exactly the cycle after E0; move_ready stays 1.
- move_valid during CHECK or OVER has no effect, and no error is raised.
- new_game asserted during CHECK aborts the check. The partial win flag is discarded, and the next cycle is IDLE with an empty board.

## Test plan
- N=3,K=3: P1 (0,0),(0,1),(0,2) with P2 (1,0),(1,1) interleaved -> result=01 four cycles after the 5th move is accepted; done=1; a 6th move_valid is ignored.
- N=3: P2 completes anti-diagonal (0,2),(1,1),(2,0) on the 6th move -> result=10; board bits 5, 9 and 13 set.
- N=3: nine moves with no line -> result=11 after the 9th check. Variant: the 9th move completes a line -> result=01, not 11.
- Rejections, each giving a one-cycle move_err with board and turn unchanged:
  - P1 plays an occupied cell.
  - P2 plays when turn=0.
  - move_row=3 with N=3.
- N=5,K=4:
  - P1 holds (0,0),(1,1),(3,3) -> result=00.
  - P1 then plays the gap (2,2) -> run=4 spans both sides -> result=01.
  - Four-in-a-row along a board edge also wins.
- new_game pulsed at E2 of a winning move's CHECK -> result stays 00, board=0, turn=0, move_ready=1 next cycle. Repeat with rst_n low mid-CHECK -> same outcome.
